// File: rtl/rab_cfg_pkg.sv
// Shared definitions for the register-access configuration master.
// Holds the transaction FSM state encoding and the AXI response codes
// that the master reports back on its response channel.
package rab_cfg_pkg;

    // Transaction FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RSP   = 2'd3
    } cfg_state_e;

    // AXI response codes used by the master.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage : rab_cfg_pkg

// File: rtl/axi_lite_cfg_master_if.sv
// AXI-Lite bus bundle between the configuration master and a slave.
// Ports: none (pure signal bundle).
//   modport master : drives AW/W/AR channels and B/R readies.
//   modport slave  : drives AW/W/AR readies and B/R channels.
interface axi_lite_cfg_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   m_axi_awaddr;
    logic                m_axi_awvalid;
    logic                m_axi_awready;
    logic [DATA_W-1:0]   m_axi_wdata;
    logic [DATA_W/8-1:0] m_axi_wstrb;
    logic                m_axi_wvalid;
    logic                m_axi_wready;
    logic [1:0]          m_axi_bresp;
    logic                m_axi_bvalid;
    logic                m_axi_bready;
    logic [ADDR_W-1:0]   m_axi_araddr;
    logic                m_axi_arvalid;
    logic                m_axi_arready;
    logic [DATA_W-1:0]   m_axi_rdata;
    logic [1:0]          m_axi_rresp;
    logic                m_axi_rvalid;
    logic                m_axi_rready;

    modport master (
        output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
        input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
        input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
    );

    modport slave (
        input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
        output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
        output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
    );
endinterface : axi_lite_cfg_master_if

// File: rtl/axi_lite_cfg_master.sv
// Single-outstanding AXI-Lite master for configuration accesses.
// A command (read or write) is accepted in IDLE, issued on the AXI bus,
// and its BRESP/RRESP plus read data is presented on the response port
// until consumed. A per-transaction watchdog aborts hung accesses.
// Ports:
//   s_axi_aclk, s_axi_aresetn : clock, asynchronous active-low reset
//   cmd_*                     : command channel (valid/ready)
//   rsp_*                     : response channel (valid/ready), timeout flag
//   m_axi                     : AXI-Lite master bus (interface, master modport)
module axi_lite_cfg_master
    import rab_cfg_pkg::*;
#(
    parameter int C_AXICFG_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES      = 1024
) (
    input  logic                             s_axi_aclk,
    input  logic                             s_axi_aresetn,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic                             cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0]        cmd_addr,
    input  logic [C_AXICFG_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_AXICFG_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [C_AXICFG_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                       rsp_resp,
    output logic                             rsp_timeout,
    axi_lite_cfg_master_if.master            m_axi
);

    localparam int DW    = C_AXICFG_DATA_WIDTH;
    localparam int SW    = C_AXICFG_DATA_WIDTH / 8;
    localparam int AW    = AXI_ADDR_WIDTH;
    // Counter only needs to reach TIMEOUT_CYCLES-1 before the abort fires.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    cfg_state_e        state_r, state_s;
    logic [AW-1:0]     awaddr_r, awaddr_s, araddr_r, araddr_s;
    logic [DW-1:0]     wdata_r, wdata_s, rsp_rdata_r, rsp_rdata_s;
    logic [SW-1:0]     wstrb_r, wstrb_s;
    logic              awvalid_r, awvalid_s, wvalid_r, wvalid_s;
    logic              bready_r, bready_s, arvalid_r, arvalid_s;
    logic              rready_r, rready_s;
    logic              aw_done_r, aw_done_s, w_done_r, w_done_s;
    logic              rsp_valid_r, rsp_valid_s, rsp_timeout_r, rsp_timeout_s;
    logic [1:0]        rsp_resp_r, rsp_resp_s;
    logic [CNT_W-1:0]  tmo_cnt_r, tmo_cnt_s;

    logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, tmo_hit_s, rsp_hs_s;

    assign aw_hs_s   = awvalid_r & m_axi.m_axi_awready;
    assign w_hs_s    = wvalid_r  & m_axi.m_axi_wready;
    assign b_hs_s    = bready_r  & m_axi.m_axi_bvalid;
    assign ar_hs_s   = arvalid_r & m_axi.m_axi_arready;
    assign r_hs_s    = rready_r  & m_axi.m_axi_rvalid;
    assign rsp_hs_s  = rsp_valid_r & rsp_ready;
    assign tmo_hit_s = (TIMEOUT_CYCLES != 0) && (tmo_cnt_r == TMO_LAST);

    // FSM state register.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; a completed handshake wins over a same-cycle timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_s = cmd_write ? ST_WRITE : ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (b_hs_s || tmo_hit_s) begin
                    state_s = ST_RSP;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_READ: begin
                if (r_hs_s || tmo_hit_s) begin
                    state_s = ST_RSP;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_RSP: begin
                if (rsp_hs_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RSP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of every registered output and of the bookkeeping flags.
    always_comb begin
        awaddr_s      = awaddr_r;
        araddr_s      = araddr_r;
        wdata_s       = wdata_r;
        wstrb_s       = wstrb_r;
        awvalid_s     = awvalid_r;
        wvalid_s      = wvalid_r;
        bready_s      = bready_r;
        arvalid_s     = arvalid_r;
        rready_s      = rready_r;
        aw_done_s     = aw_done_r;
        w_done_s      = w_done_r;
        rsp_valid_s   = rsp_valid_r;
        rsp_rdata_s   = rsp_rdata_r;
        rsp_resp_s    = rsp_resp_r;
        rsp_timeout_s = rsp_timeout_r;
        tmo_cnt_s     = tmo_cnt_r;
        case (state_r)
            ST_IDLE: begin
                tmo_cnt_s = '0;
                aw_done_s = 1'b0;
                w_done_s  = 1'b0;
                if (cmd_valid && cmd_write) begin
                    awaddr_s  = cmd_addr;
                    wdata_s   = cmd_wdata;
                    wstrb_s   = cmd_wstrb;
                    awvalid_s = 1'b1;
                    wvalid_s  = 1'b1;
                end else if (cmd_valid) begin
                    araddr_s  = cmd_addr;
                    arvalid_s = 1'b1;
                end else begin
                    awvalid_s = 1'b0;
                    arvalid_s = 1'b0;
                end
            end
            ST_WRITE: begin
                tmo_cnt_s = tmo_cnt_r + CNT_W'(1);
                // AW and W retire independently, in either order.
                aw_done_s = aw_done_r | aw_hs_s;
                w_done_s  = w_done_r  | w_hs_s;
                awvalid_s = awvalid_r & ~m_axi.m_axi_awready;
                wvalid_s  = wvalid_r  & ~m_axi.m_axi_wready;
                if (b_hs_s) begin
                    bready_s      = 1'b0;
                    rsp_valid_s   = 1'b1;
                    rsp_resp_s    = m_axi.m_axi_bresp;
                    rsp_rdata_s   = '0;
                    rsp_timeout_s = 1'b0;
                end else if (tmo_hit_s) begin
                    // Abandon a hung slave: withdraw everything we offered.
                    awvalid_s     = 1'b0;
                    wvalid_s      = 1'b0;
                    bready_s      = 1'b0;
                    rsp_valid_s   = 1'b1;
                    rsp_resp_s    = RESP_SLVERR;
                    rsp_rdata_s   = '0;
                    rsp_timeout_s = 1'b1;
                end else begin
                    bready_s = aw_done_s & w_done_s;
                end
            end
            ST_READ: begin
                tmo_cnt_s = tmo_cnt_r + CNT_W'(1);
                arvalid_s = arvalid_r & ~m_axi.m_axi_arready;
                if (r_hs_s) begin
                    rready_s      = 1'b0;
                    rsp_valid_s   = 1'b1;
                    rsp_resp_s    = m_axi.m_axi_rresp;
                    rsp_rdata_s   = m_axi.m_axi_rdata;
                    rsp_timeout_s = 1'b0;
                end else if (tmo_hit_s) begin
                    arvalid_s     = 1'b0;
                    rready_s      = 1'b0;
                    rsp_valid_s   = 1'b1;
                    rsp_resp_s    = RESP_SLVERR;
                    rsp_rdata_s   = '0;
                    rsp_timeout_s = 1'b1;
                end else begin
                    rready_s = rready_r | ar_hs_s;
                end
            end
            ST_RSP: begin
                if (rsp_hs_s) begin
                    rsp_valid_s = 1'b0;
                    tmo_cnt_s   = '0;
                end else begin
                    rsp_valid_s = 1'b1;
                end
            end
            default: begin
                awvalid_s   = 1'b0;
                wvalid_s    = 1'b0;
                bready_s    = 1'b0;
                arvalid_s   = 1'b0;
                rready_s    = 1'b0;
                rsp_valid_s = 1'b0;
                tmo_cnt_s   = '0;
            end
        endcase
    end

    // Output and bookkeeping registers; reset clears the bus outputs too.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            awaddr_r      <= '0;
            araddr_r      <= '0;
            wdata_r       <= '0;
            wstrb_r       <= '0;
            awvalid_r     <= 1'b0;
            wvalid_r      <= 1'b0;
            bready_r      <= 1'b0;
            arvalid_r     <= 1'b0;
            rready_r      <= 1'b0;
            aw_done_r     <= 1'b0;
            w_done_r      <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= '0;
            rsp_resp_r    <= 2'b00;
            rsp_timeout_r <= 1'b0;
            tmo_cnt_r     <= '0;
        end else begin
            awaddr_r      <= awaddr_s;
            araddr_r      <= araddr_s;
            wdata_r       <= wdata_s;
            wstrb_r       <= wstrb_s;
            awvalid_r     <= awvalid_s;
            wvalid_r      <= wvalid_s;
            bready_r      <= bready_s;
            arvalid_r     <= arvalid_s;
            rready_r      <= rready_s;
            aw_done_r     <= aw_done_s;
            w_done_r      <= w_done_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_rdata_r   <= rsp_rdata_s;
            rsp_resp_r    <= rsp_resp_s;
            rsp_timeout_r <= rsp_timeout_s;
            tmo_cnt_r     <= tmo_cnt_s;
        end
    end

    assign cmd_ready   = (state_r == ST_IDLE);
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_resp    = rsp_resp_r;
    assign rsp_timeout = rsp_timeout_r;

    assign m_axi.m_axi_awaddr  = awaddr_r;
    assign m_axi.m_axi_awvalid = awvalid_r;
    assign m_axi.m_axi_wdata   = wdata_r;
    assign m_axi.m_axi_wstrb   = wstrb_r;
    assign m_axi.m_axi_wvalid  = wvalid_r;
    assign m_axi.m_axi_bready  = bready_r;
    assign m_axi.m_axi_araddr  = araddr_r;
    assign m_axi.m_axi_arvalid = arvalid_r;
    assign m_axi.m_axi_rready  = rready_r;

endmodule : axi_lite_cfg_master

// File: tb/tb_axi_lite_cfg_master.sv
// Directed bench for axi_lite_cfg_master with a small reactive AXI-Lite
// slave (16-word memory, programmable ready delays, stall knobs, BRESP).
module tb_axi_lite_cfg_master;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    int n_chk  = 0;
    int n_fail = 0;

    axi_lite_cfg_master_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    axi_lite_cfg_master #(
        .C_AXICFG_DATA_WIDTH(32),
        .AXI_ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES     (8)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(rstn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_wstrb    (cmd_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .rsp_timeout  (rsp_timeout),
        .m_axi        (axi.master)
    );

    always #5 clk = ~clk;

    // Slave model state and knobs.
    logic [31:0] mem [0:15];
    int          aw_delay = 0, w_delay = 0, aw_cnt, w_cnt, b_cnt;
    bit          aw_stall = 1'b0, ar_stall = 1'b0;
    logic [1:0]  bresp_k = 2'b00;
    logic        aw_got, w_got;
    logic [31:0] aw_a, w_d;
    logic [3:0]  w_s;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            axi.m_axi_awready <= 1'b0; axi.m_axi_wready <= 1'b0;
            axi.m_axi_arready <= 1'b0; axi.m_axi_bvalid <= 1'b0;
            axi.m_axi_rvalid  <= 1'b0; axi.m_axi_bresp  <= 2'b00;
            axi.m_axi_rresp   <= 2'b00; axi.m_axi_rdata <= 32'h0;
            aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            aw_a <= 32'h0; w_d <= 32'h0; w_s <= 4'h0;
        end else begin
            if (axi.m_axi_awvalid && axi.m_axi_awready) begin
                axi.m_axi_awready <= 1'b0; aw_got <= 1'b1; aw_a <= axi.m_axi_awaddr; aw_cnt <= 0;
            end else if (!axi.m_axi_awvalid) begin
                axi.m_axi_awready <= 1'b0; aw_cnt <= 0;
            end else if (!aw_stall) begin
                if (aw_cnt >= aw_delay) axi.m_axi_awready <= 1'b1;
                else aw_cnt <= aw_cnt + 1;
            end
            if (axi.m_axi_wvalid && axi.m_axi_wready) begin
                axi.m_axi_wready <= 1'b0; w_got <= 1'b1; w_d <= axi.m_axi_wdata;
                w_s <= axi.m_axi_wstrb; w_cnt <= 0;
            end else if (!axi.m_axi_wvalid) begin
                axi.m_axi_wready <= 1'b0; w_cnt <= 0;
            end else begin
                if (w_cnt >= w_delay) axi.m_axi_wready <= 1'b1;
                else w_cnt <= w_cnt + 1;
            end
            if (axi.m_axi_bvalid && axi.m_axi_bready) begin
                axi.m_axi_bvalid <= 1'b0; b_cnt <= b_cnt + 1;
                aw_got <= 1'b0; w_got <= 1'b0;
                for (int b = 0; b < 4; b++)
                    if (w_s[b]) mem[aw_a[5:2]][8*b +: 8] <= w_d[8*b +: 8];
            end else if (!axi.m_axi_bvalid &&
                         (aw_got || (axi.m_axi_awvalid && axi.m_axi_awready)) &&
                         (w_got  || (axi.m_axi_wvalid  && axi.m_axi_wready))) begin
                axi.m_axi_bvalid <= 1'b1; axi.m_axi_bresp <= bresp_k;
            end
            if (axi.m_axi_arvalid && axi.m_axi_arready) begin
                axi.m_axi_arready <= 1'b0; axi.m_axi_rvalid <= 1'b1;
                axi.m_axi_rdata <= mem[axi.m_axi_araddr[5:2]]; axi.m_axi_rresp <= 2'b00;
            end else if (axi.m_axi_arvalid && !ar_stall) begin
                axi.m_axi_arready <= 1'b1;
            end else begin
                axi.m_axi_arready <= 1'b0;
            end
            if (axi.m_axi_rvalid && axi.m_axi_rready) axi.m_axi_rvalid <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first issue cycle.
    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        logic ok = 1'b0;
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("cmd_accept", ok, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid) break;
            @(negedge clk);
        end
        chk("rsp_seen", rsp_valid, 1);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_drop", rsp_valid, 0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_awvalid"}, axi.m_axi_awvalid, 0);
        chk({tag, "_wvalid"},  axi.m_axi_wvalid, 0);
        chk({tag, "_bready"},  axi.m_axi_bready, 0);
        chk({tag, "_arvalid"}, axi.m_axi_arvalid, 0);
        chk({tag, "_rready"},  axi.m_axi_rready, 0);
        chk({tag, "_rspv"},    rsp_valid, 0);
        chk({tag, "_rsptmo"},  rsp_timeout, 0);
        chk({tag, "_rspresp"}, rsp_resp, 0);
        chk({tag, "_rspdata"}, rsp_rdata, 0);
        chk({tag, "_awaddr"},  axi.m_axi_awaddr, 0);
        chk({tag, "_araddr"},  axi.m_axi_araddr, 0);
        chk({tag, "_wdata"},   axi.m_axi_wdata, 0);
        chk({tag, "_wstrb"},   axi.m_axi_wstrb, 0);
    endtask

    initial begin
        int b0;
        int n_ar;
        rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
        cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b0; b_cnt = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rstn = 1'b1;
        @(negedge clk);
        chk("reset_cmd_ready", cmd_ready, 1);

        // Basic write, slave ready
        send_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        chk("w1_awvalid", axi.m_axi_awvalid, 1);
        chk("w1_wvalid",  axi.m_axi_wvalid, 1);
        chk("w1_awaddr",  axi.m_axi_awaddr, 32'h0000_0010);
        chk("w1_wdata",   axi.m_axi_wdata, 32'hDEAD_BEEF);
        chk("w1_wstrb",   axi.m_axi_wstrb, 4'hF);
        chk("w1_cmd_rdy", cmd_ready, 0);
        wait_rsp();
        chk("w1_resp", rsp_resp, 2'b00);
        chk("w1_tmo",  rsp_timeout, 0);
        chk("w1_rdata", rsp_rdata, 32'h0);
        consume();

        // Write with AW accepted 3 cycles after W; slave answers SLVERR
        aw_delay = 3; bresp_k = 2'b10; b0 = b_cnt;
        send_cmd(1'b1, 32'h0000_0014, 32'h1234_5678, 4'hF);
        @(negedge clk); @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            chk("w2_wvalid_done", axi.m_axi_wvalid, 0);
            chk("w2_awvalid_hold", axi.m_axi_awvalid, 1);
            chk("w2_bready_early", axi.m_axi_bready, 0);
            @(negedge clk);
        end
        chk("w2_bready_up", axi.m_axi_bready, 1);
        chk("w2_awvalid_down", axi.m_axi_awvalid, 0);
        wait_rsp();
        chk("w2_resp", rsp_resp, 2'b10);
        chk("w2_tmo",  rsp_timeout, 0);
        consume();
        repeat (3) @(negedge clk);
        chk("w2_single_b", 64'(b_cnt - b0), 1);
        aw_delay = 0; bresp_k = 2'b00;

        // Read back, hold response, back-to-back command
        send_cmd(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        chk("r1_arvalid", axi.m_axi_arvalid, 1);
        chk("r1_araddr",  axi.m_axi_araddr, 32'h0000_0010);
        chk("r1_awvalid", axi.m_axi_awvalid, 0);
        wait_rsp();
        chk("r1_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("r1_resp",  rsp_resp, 2'b00);
        cmd_write = 1'b0; cmd_addr = 32'h0000_0014; cmd_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("r1_hold_rspv", rsp_valid, 1);
            chk("r1_hold_cmdrdy", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("b2b_rspv", rsp_valid, 0);
        chk("b2b_cmdrdy", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2b_arvalid", axi.m_axi_arvalid, 1);
        chk("b2b_araddr",  axi.m_axi_araddr, 32'h0000_0014);
        wait_rsp();
        chk("b2b_rdata", rsp_rdata, 32'h1234_5678);
        consume();

        // Partial-strobe write then read
        send_cmd(1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'b0101);
        chk("ws_wstrb", axi.m_axi_wstrb, 4'b0101);
        wait_rsp();
        consume();
        send_cmd(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        wait_rsp();
        chk("ws_rdata", rsp_rdata, 32'hDEBB_BEDD);
        consume();

        // Timeout on stuck AR
        ar_stall = 1'b1;
        send_cmd(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        n_ar = 0;
        for (int i = 0; i < 50; i++) begin
            if (!axi.m_axi_arvalid) break;
            n_ar++;
            @(negedge clk);
        end
        chk("tmo_ar_cycles", 64'(n_ar), 8);
        chk("tmo_rspv",  rsp_valid, 1);
        chk("tmo_flag",  rsp_timeout, 1);
        chk("tmo_resp",  rsp_resp, 2'b10);
        chk("tmo_rdata", rsp_rdata, 32'h0);
        chk("tmo_rready", axi.m_axi_rready, 0);
        consume();
        ar_stall = 1'b0;

        // Reset in the middle of a write
        aw_stall = 1'b1;
        send_cmd(1'b1, 32'h0000_0018, 32'hCAFE_F00D, 4'hF);
        @(negedge clk);
        chk("rst_pre_awvalid", axi.m_axi_awvalid, 1);
        rstn = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        @(negedge clk);
        rstn = 1'b1; aw_stall = 1'b0;
        @(negedge clk);
        send_cmd(1'b1, 32'h0000_0018, 32'hCAFE_F00D, 4'hF);
        wait_rsp();
        chk("post_rst_wresp", rsp_resp, 2'b00);
        consume();
        send_cmd(1'b0, 32'h0000_0018, 32'h0, 4'h0);
        wait_rsp();
        chk("post_rst_rdata", rsp_rdata, 32'hCAFE_F00D);
        chk("post_rst_tmo", rsp_timeout, 0);
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_axi_lite_cfg_master

// File: doc/axi_lite_cfg_master.md
AXI_LITE_CFG_MASTER -- requirements
Module: axi_lite_cfg_master

Interface
REQ-001 SHALL have parameter C_AXICFG_DATA_WIDTH, default 32, AXI-Lite data width.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, AXI-Lite address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, transaction abort limit; 0 disables the timeout.
REQ-004 SHALL have port s_axi_aclk  in  1  clock.
REQ-005 SHALL have port s_axi_aresetn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid  in  1  command offered.
REQ-007 SHALL have port cmd_ready  out  1  command accepted.
REQ-008 SHALL have port cmd_write  in  1  1=write, 0=read.
REQ-009 SHALL have port cmd_addr  in  AXI_ADDR_WIDTH  target byte address.
REQ-010 SHALL have port cmd_wdata  in  C_AXICFG_DATA_WIDTH  write data.
REQ-011 SHALL have port cmd_wstrb  in  C_AXICFG_DATA_WIDTH/8  write byte strobes.
REQ-012 SHALL have port rsp_valid  out  1  response available.
REQ-013 SHALL have port rsp_ready  in  1  response consumed.
REQ-014 SHALL have port rsp_rdata  out  C_AXICFG_DATA_WIDTH  read data, 0 for writes.
REQ-015 SHALL have port rsp_resp  out  2  captured BRESP/RRESP.
REQ-016 SHALL have port rsp_timeout  out  1  transaction aborted by timeout.
REQ-017 SHALL have port m_axi_awaddr  out  AXI_ADDR_WIDTH  write address.
REQ-018 SHALL have port m_axi_awvalid  out  1  AW valid.
REQ-019 SHALL have port m_axi_awready  in  1  AW ready.
REQ-020 SHALL have port m_axi_wdata  out  C_AXICFG_DATA_WIDTH  write data.
REQ-021 SHALL have port m_axi_wstrb  out  C_AXICFG_DATA_WIDTH/8  write strobes.
REQ-022 SHALL have port m_axi_wvalid  out  1  W valid.
REQ-023 SHALL have port m_axi_wready  in  1  W ready.
REQ-024 SHALL have port m_axi_bresp  in  2  write response.
REQ-025 SHALL have port m_axi_bvalid  in  1  B valid.
REQ-026 SHALL have port m_axi_bready  out  1  B ready.
REQ-027 SHALL have port m_axi_araddr  out  AXI_ADDR_WIDTH  read address.
REQ-028 SHALL have port m_axi_arvalid  out  1  AR valid.
REQ-029 SHALL have port m_axi_arready  in  1  AR ready.
REQ-030 SHALL have port m_axi_rdata  in  C_AXICFG_DATA_WIDTH  read data.
REQ-031 SHALL have port m_axi_rresp  in  2  read response.
REQ-032 SHALL have port m_axi_rvalid  in  1  R valid.
REQ-033 SHALL have port m_axi_rready  out  1  R ready.

Function
REQ-034 SHALL implement FSM IDLE, WRITE, READ, RSP; cmd_ready = (state==IDLE); all outputs registered except cmd_ready.
REQ-035 SHALL, on cmd_valid&cmd_ready, latch addr/data/strb and, next cycle, assert awvalid+wvalid (write) or arvalid (read); one outstanding transaction only.
REQ-036 WRITE: SHALL hold awvalid/wvalid stable until their own handshakes, independently in any order, same-cycle allowed; SHALL assert bready only once both AW and W are done; B handshake -> RSP.
REQ-037 READ: SHALL hold arvalid until handshake, then assert rready; R handshake captures rdata/rresp -> RSP.
REQ-038 RSP: SHALL drive rsp_valid=1 from the cycle after the B/R handshake until rsp_ready; rsp_valid&rsp_ready -> IDLE, so a back-to-back cmd_valid is accepted one cycle later.
REQ-039 SHALL count cycles spent in WRITE/READ; on reaching TIMEOUT_CYCLES, drop all AXI valids/readies (deliberate hung-slave recovery), enter RSP with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0; counter clears on entering IDLE.
REQ-040 SHALL ignore bvalid/rvalid arriving in IDLE or RSP (bready/rready low).

Reset
REQ-041 SHALL, on asynchronous reset (mid-transaction included), force IDLE, all valids/readies 0, rsp_* 0, counter 0, and m_axi address/data/strb outputs 0.

Structure
REQ-042 SHALL take the FSM state enum and the RESP_OKAY/RESP_SLVERR constants from a shared package, rab_cfg_pkg.
REQ-043 SHALL be a single module with no sub-modules.

Verification
REQ-044 Write 0x0000_0010 data 0xDEAD_BEEF strb 0xF, slave ready -> awvalid/wvalid in cycle 1, rsp_resp=00, rsp_timeout=0.
REQ-045 Write with awready delayed 3 cycles after wready -> bready rises only after AW done, single B consumed.
REQ-046 Read 0x0000_0010 after REQ-044 -> rsp_rdata=0xDEAD_BEEF, rsp_resp=00; rsp_ready held low 5 cycles -> rsp_valid stays 1, cmd_ready stays 0.
REQ-047 TIMEOUT_CYCLES=8, arready stuck 0 -> arvalid drops after 8 cycles, rsp_timeout=1, rsp_resp=10, rsp_rdata=0.
REQ-048 Reset asserted while awvalid=1 -> all outputs 0 immediately, next command completes normally.
